// File: rtl/space_wire_stat_reg_if_pkg.sv
// Shared definitions for the SpaceWire statistics register interface:
// register addresses, CTRL bit positions, counter indices, FSM encoding
// and a helper that formats the CTRL status byte.
package space_wire_stat_reg_if_pkg;

  localparam int unsigned NUM_CNT   = 8;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MON_W     = 7;
  localparam int unsigned CLR_CNT_W = 4;

  // Register map
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_STICKY = 6'h21;
  localparam logic [ADDR_W-1:0] ADDR_LIVE   = 6'h22;

  // CTRL write bits
  localparam int unsigned CTRL_SNAP_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT  = 1;

  // Counter positions on the counter bus
  localparam int unsigned CNT_TX_EOP    = 0;
  localparam int unsigned CNT_RX_EOP    = 1;
  localparam int unsigned CNT_TX_EEP    = 2;
  localparam int unsigned CNT_RX_EEP    = 3;
  localparam int unsigned CNT_TX_BYTE   = 4;
  localparam int unsigned CNT_RX_BYTE   = 5;
  localparam int unsigned CNT_LINK_UP   = 6;
  localparam int unsigned CNT_LINK_DOWN = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_SNAP    = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_CLRWAIT = 3'd4
  } state_e;

  // CTRL read value: {6'b0, clr_busy, snap_valid}
  function automatic logic [DATA_W-1:0] ctrl_status(input logic clr_busy,
                                                    input logic snap_valid);
    return {6'b0, clr_busy, snap_valid};
  endfunction

endpackage

// File: rtl/space_wire_stat_reg_if_if.sv
// Host access bus of the statistics register block.
//   i_req   : request, held until o_ack      i_wr    : 1=write, 0=read
//   i_addr  : byte address                   i_wdata : write data
//   o_ack   : one-cycle completion           o_rdata : read data (valid with o_ack)
// Signal names are seen from the register block (slave) side.
interface space_wire_stat_reg_if_if;
  import space_wire_stat_reg_if_pkg::*;

  logic              i_req;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_ack;
  logic [DATA_W-1:0] o_rdata;

  modport master (output i_req, i_wr, i_addr, i_wdata, input  o_ack, o_rdata);
  modport slave  (input  i_req, i_wr, i_addr, i_wdata, output o_ack, o_rdata);
endinterface

// File: rtl/space_wire_stat_snapshot.sv
// Snapshot storage for the eight statistics counters.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_cap          : latch all eight counters from i_cnt_bus this cycle
//   i_cnt_bus      : counter n at [n*CNT_W +: CNT_W]
//   i_sel          : byte select, counter = i_sel[4:2], byte = i_sel[1:0]
//   o_byte_c       : combinational selected byte (zero-extended beyond CNT_W)
module space_wire_stat_snapshot
  import space_wire_stat_reg_if_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_cap,
  input  logic [NUM_CNT*CNT_W-1:0]   i_cnt_bus,
  input  logic [4:0]                 i_sel,
  output logic [DATA_W-1:0]          o_byte_c
);

  logic [CNT_W-1:0] snap_q [NUM_CNT];
  logic [31:0]      snap_word_c;

  // All counters captured on the same edge so the set is coherent
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < NUM_CNT; n++) snap_q[n] <= '0;
    end else if (i_cap) begin
      for (int n = 0; n < NUM_CNT; n++) snap_q[n] <= i_cnt_bus[n*CNT_W +: CNT_W];
    end
  end

  // Little-endian byte select from the zero-extended counter word
  always_comb begin
    snap_word_c = 32'(snap_q[i_sel[4:2]]);
    o_byte_c    = snap_word_c[{i_sel[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/space_wire_stat_reg_if.sv
// Host register interface for the SpaceWire statistics block: counter
// snapshot, counter clear sequencing, sticky event flags and live events.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_cnt_bus      : eight CNT_W-bit counters from the statistics block
//   i_char_mon     : one-shot event pulses
//   host           : host access bus (slave side)
//   o_stat_clear   : counter clear pulse, CLR_CYCLES cycles long
module space_wire_stat_reg_if
  import space_wire_stat_reg_if_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_CNT*CNT_W-1:0] i_cnt_bus,
  input  logic [MON_W-1:0]         i_char_mon,
  space_wire_stat_reg_if_if.slave  host,
  output logic                     o_stat_clear
);

  state_e                 state_q;
  logic                   ack_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   stat_clear_q;
  logic [CLR_CNT_W-1:0]   clr_cnt_q;
  logic                   clr_pend_q;
  logic                   snap_valid_q;
  logic [MON_W-1:0]       sticky_q;
  logic [MON_W-1:0]       sticky_d;

  logic                   accept_c;
  logic                   ctrl_wr_c;
  logic                   clr_busy_c;
  logic                   snap_cap_c;
  logic [MON_W-1:0]       w1c_mask_c;
  logic [DATA_W-1:0]      snap_byte_c;
  logic [DATA_W-1:0]      rd_byte_c;
  logic                   unused_wdata;

  assign accept_c     = (state_q == ST_IDLE) && host.i_req;
  assign ctrl_wr_c    = host.i_wr && (host.i_addr == ADDR_CTRL);
  assign clr_busy_c   = (state_q == ST_CLEAR) || (state_q == ST_CLRWAIT);
  assign snap_cap_c   = (state_q == ST_SNAP);
  assign unused_wdata = host.i_wdata[7];

  assign host.o_ack   = ack_q;
  assign host.o_rdata = rdata_q;
  assign o_stat_clear = stat_clear_q;

  space_wire_stat_snapshot #(.CNT_W(CNT_W)) u_snap (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_cap     (snap_cap_c),
    .i_cnt_bus (i_cnt_bus),
    .i_sel     (host.i_addr[4:0]),
    .o_byte_c  (snap_byte_c)
  );

  // Sticky flags: W1C at acceptance, new pulses win over the clear
  always_comb begin
    w1c_mask_c = '0;
    if (accept_c && host.i_wr && (host.i_addr == ADDR_STICKY)) begin
      w1c_mask_c = host.i_wdata[MON_W-1:0];
    end
    sticky_d = (sticky_q & ~w1c_mask_c) | i_char_mon;
  end

  // Read mux, evaluated at the acceptance cycle
  always_comb begin
    rd_byte_c = '0;
    if (!host.i_addr[5]) begin
      rd_byte_c = snap_byte_c;
    end else begin
      case (host.i_addr)
        ADDR_CTRL:   rd_byte_c = ctrl_status(clr_busy_c, snap_valid_q);
        ADDR_STICKY: rd_byte_c = {1'b0, sticky_q};
        ADDR_LIVE:   rd_byte_c = {1'b0, i_char_mon};
        default:     rd_byte_c = '0;
      endcase
    end
  end

  // Access FSM with registered ack, read data and clear pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      stat_clear_q <= 1'b0;
      clr_cnt_q    <= '0;
      clr_pend_q   <= 1'b0;
      snap_valid_q <= 1'b0;
      sticky_q     <= '0;
    end else begin
      sticky_q <= sticky_d;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (ctrl_wr_c && host.i_wdata[CTRL_SNAP_BIT]) begin
              state_q    <= ST_SNAP;
              clr_pend_q <= host.i_wdata[CTRL_CLR_BIT];
            end else if (ctrl_wr_c && host.i_wdata[CTRL_CLR_BIT]) begin
              state_q      <= ST_CLEAR;
              stat_clear_q <= 1'b1;
              clr_cnt_q    <= '0;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              rdata_q <= host.i_wr ? '0 : rd_byte_c;
            end
          end
        end
        ST_SNAP: begin
          // Capture happens this cycle, so a following clear sees pre-clear values saved
          snap_valid_q <= 1'b1;
          clr_pend_q   <= 1'b0;
          if (clr_pend_q) begin
            state_q      <= ST_CLEAR;
            stat_clear_q <= 1'b1;
            clr_cnt_q    <= '0;
          end else begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_CNT_W'(CLR_CYCLES - 1)) begin
            state_q      <= ST_CLRWAIT;
            stat_clear_q <= 1'b0;
            clr_cnt_q    <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_CLRWAIT: begin
          state_q <= ST_ACK;
          ack_q   <= 1'b1;
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q      <= ST_IDLE;
          ack_q        <= 1'b0;
          rdata_q      <= '0;
          stat_clear_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
